// File: rtl/exu_bp_update_q_if.sv
// Branch-predictor update queue bundle: ALU write side, commit/kill control,
// IFU update side and error pulses. master = producer/consumer side, slave = queue.
interface exu_bp_update_q_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [30:0] wr_pc;
    logic        wr_misp;
    logic        wr_ataken;
    logic [1:0]  wr_hist;
    logic        commit;
    logic        kill;
    logic        upd_valid;
    logic        upd_ready;
    logic [30:0] upd_pc;
    logic        upd_misp;
    logic        upd_ataken;
    logic [1:0]  upd_hist;
    logic        ovf_err;
    logic        cm_err;

    modport master (
        output wr_valid, wr_pc, wr_misp, wr_ataken, wr_hist, commit, kill, upd_ready,
        input  wr_ready, upd_valid, upd_pc, upd_misp, upd_ataken, upd_hist, ovf_err, cm_err
    );

    modport slave (
        input  wr_valid, wr_pc, wr_misp, wr_ataken, wr_hist, commit, kill, upd_ready,
        output wr_ready, upd_valid, upd_pc, upd_misp, upd_ataken, upd_hist, ovf_err, cm_err
    );
endinterface

// File: rtl/exu_bp_update_q.sv
// In-order queue holding resolved branches until commit, then feeding the IFU predictor.
// Optional saturating pop/mispredict counters enabled by EXU_BPQ_STATS_EN.
module exu_bp_update_q #(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_l,
    exu_bp_update_q_if.slave       bp
`ifdef EXU_BPQ_STATS_EN
    ,
    output logic [15:0]            stat_upd_cnt,
    output logic [15:0]            stat_misp_cnt
`endif
);

    typedef struct packed {
        logic [30:0] pc;
        logic        misp;
        logic        ataken;
        logic [1:0]  hist;
    } entry_t;

    localparam logic [PTRW:0] DEPTH_W = (PTRW + 1)'(DEPTH);

    entry_t          mem [DEPTH];
    logic [PTRW:0]   rd_q, rd_d;
    logic [PTRW:0]   cm_q, cm_d;
    logic [PTRW:0]   wr_q, wr_d;
    logic            ovf_q, ovf_d;
    logic            cm_err_q, cm_err_d;

    logic [PTRW:0]   ncommitted;
    logic [PTRW:0]   nspec;
    logic [PTRW:0]   total;
    logic            wr_ready;
    logic            wr_acc;
    logic            pop;
    logic            cm_ok;
    entry_t          head;

    assign ncommitted = cm_q - rd_q;
    assign nspec      = wr_q - cm_q;
    assign total      = wr_q - rd_q;

    // Registered occupancy only: a pop in this cycle does not free a slot until next cycle.
    assign wr_ready = (total != DEPTH_W);
    assign wr_acc   = bp.wr_valid & wr_ready & ~bp.kill;
    assign pop      = (ncommitted != '0) & bp.upd_ready;
    assign cm_ok    = bp.commit & (nspec != '0);

    always_comb begin
        rd_d     = rd_q;
        cm_d     = cm_q;
        wr_d     = wr_q;
        ovf_d    = 1'b0;
        cm_err_d = 1'b0;

        if (pop)
            rd_d = rd_q + 1'b1;
        if (cm_ok)
            cm_d = cm_q + 1'b1;
        cm_err_d = bp.commit & ~cm_ok;

        // Kill truncates to the post-commit boundary and swallows any same-cycle write.
        if (bp.kill)
            wr_d = cm_d;
        else if (wr_acc)
            wr_d = wr_q + 1'b1;

        ovf_d = bp.wr_valid & ~wr_ready & ~bp.kill;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            rd_q     <= '0;
            cm_q     <= '0;
            wr_q     <= '0;
            ovf_q    <= 1'b0;
            cm_err_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            cm_q     <= cm_d;
            wr_q     <= wr_d;
            ovf_q    <= ovf_d;
            cm_err_q <= cm_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_q[PTRW-1:0]] <= '{pc: bp.wr_pc, misp: bp.wr_misp,
                                     ataken: bp.wr_ataken, hist: bp.wr_hist};
    end

    assign head          = mem[rd_q[PTRW-1:0]];
    assign bp.wr_ready   = wr_ready;
    assign bp.upd_valid  = (ncommitted != '0);
    assign bp.upd_pc     = head.pc;
    assign bp.upd_misp   = head.misp;
    assign bp.upd_ataken = head.ataken;
    assign bp.upd_hist   = head.hist;
    assign bp.ovf_err    = ovf_q;
    assign bp.cm_err     = cm_err_q;

`ifdef EXU_BPQ_STATS_EN
    logic [15:0] stat_upd_q;
    logic [15:0] stat_misp_q;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            stat_upd_q  <= '0;
            stat_misp_q <= '0;
        end else if (pop) begin
            if (stat_upd_q != 16'hFFFF)
                stat_upd_q <= stat_upd_q + 16'd1;
            if (head.misp && (stat_misp_q != 16'hFFFF))
                stat_misp_q <= stat_misp_q + 16'd1;
        end
    end

    assign stat_upd_cnt  = stat_upd_q;
    assign stat_misp_cnt = stat_misp_q;
`endif

endmodule

// File: tb/tb_exu_bp_update_q.sv
// Self-checking bench for exu_bp_update_q: queue-based reference model with an
// expected-pop scoreboard compared against the packets the DUT actually pops.
module tb_exu_bp_update_q;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [30:0] pc;
        logic        misp;
        logic        ataken;
        logic [1:0]  hist;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    exu_bp_update_q_if bpif();

`ifdef EXU_BPQ_STATS_EN
    logic [15:0] stat_upd_cnt;
    logic [15:0] stat_misp_cnt;
`endif

    exu_bp_update_q #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bp    (bpif)
`ifdef EXU_BPQ_STATS_EN
        ,
        .stat_upd_cnt  (stat_upd_cnt),
        .stat_misp_cnt (stat_misp_cnt)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    pkt_t m_ent[$];
    pkt_t exp_q[$];
    pkt_t act_q[$];
    int   m_ncm = 0;
    logic m_ovf = 1'b0;
    logic m_cmerr = 1'b0;

    function automatic pkt_t mk(int i);
        pkt_t p;
        p.pc     = 31'(32'h800 + 32'(i));
        p.misp   = i[0];
        p.ataken = i[1];
        p.hist   = i[1:0];
        return p;
    endfunction

    task automatic set_in(bit wv, pkt_t p, bit cmt, bit kl, bit urdy);
        bpif.wr_valid  = wv;
        bpif.wr_pc     = p.pc;
        bpif.wr_misp   = p.misp;
        bpif.wr_ataken = p.ataken;
        bpif.wr_hist   = p.hist;
        bpif.commit    = cmt;
        bpif.kill      = kl;
        bpif.upd_ready = urdy;
    endtask

    // Advance one clock: record the DUT pop, step the reference model, land on the next negedge.
    task automatic tick();
        int   total;
        int   nspec;
        bit   ready;
        pkt_t p;
        if (!rst_l) begin
            m_ent.delete();
            m_ncm   = 0;
            m_ovf   = 1'b0;
            m_cmerr = 1'b0;
        end else begin
            if (bpif.upd_valid && bpif.upd_ready)
                act_q.push_back({bpif.upd_pc, bpif.upd_misp, bpif.upd_ataken, bpif.upd_hist});
            total   = m_ent.size();
            nspec   = total - m_ncm;
            ready   = (total != DEPTH);
            m_ovf   = bpif.wr_valid && !ready && !bpif.kill;
            m_cmerr = bpif.commit && (nspec == 0);
            if (m_ncm != 0 && bpif.upd_ready) begin
                exp_q.push_back(m_ent.pop_front());
                m_ncm--;
            end
            if (bpif.commit && nspec != 0)
                m_ncm++;
            if (bpif.kill) begin
                while (m_ent.size() > m_ncm)
                    void'(m_ent.pop_back());
            end else if (bpif.wr_valid && ready) begin
                p = {bpif.wr_pc, bpif.wr_misp, bpif.wr_ataken, bpif.wr_hist};
                m_ent.push_back(p);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(0, '0, 0, 0, 0);
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        checks++;
        if (bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wr_ready got %b want 1", bpif.wr_ready);
        end
        checks++;
        if (bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_upd_valid got %b want 0", bpif.upd_valid);
        end
        checks++;
        if (bpif.ovf_err !== 1'b0 || bpif.cm_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got ovf=%b cm=%b want 0 0", bpif.ovf_err, bpif.cm_err);
        end
    endtask

    task automatic test_basic();
        pkt_t p;
        act_q.delete(); exp_q.delete();
        p = {31'h800, 1'b1, 1'b1, 2'b11};
        set_in(1, p, 0, 0, 1);
        tick();
        set_in(0, '0, 1, 0, 1);
        checks++;
        if (bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid got %b want 0", bpif.upd_valid);
        end
        tick();
        set_in(0, '0, 0, 0, 1);
        checks++;
        if (bpif.upd_valid !== 1'b1 || bpif.upd_pc !== 31'h800 || bpif.upd_misp !== 1'b1
            || bpif.upd_hist !== 2'b11) begin
            errors++;
            $display("FAIL basic_head got v=%b pc=%h misp=%b hist=%b want 1 800 1 11",
                     bpif.upd_valid, bpif.upd_pc, bpif.upd_misp, bpif.upd_hist);
        end
        tick();
        checks++;
        if (bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL basic_after_pop got %b want 0", bpif.upd_valid);
        end
        checks++;
        if (act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== p) begin
            errors++; $display("FAIL basic_pop got n=%0d want 1 pkt %h", act_q.size(), p);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, mk(i), 0, 0, 0);
            tick();
        end
        checks++;
        if (bpif.wr_ready !== 1'b0 || bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL full_state got rdy=%b v=%b want 0 0", bpif.wr_ready, bpif.upd_valid);
        end
        set_in(1, mk(9), 0, 0, 0);
        tick();
        checks++;
        if (bpif.ovf_err !== 1'b1 || m_ovf !== 1'b1) begin
            errors++; $display("FAIL full_ovf got %b want 1", bpif.ovf_err);
        end
        checks++;
        if (bpif.wr_ready !== 1'b0 || m_ent.size() != DEPTH || bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL full_hold got rdy=%b v=%b want 0 0", bpif.wr_ready, bpif.upd_valid);
        end
        set_in(0, '0, 0, 1, 0);
        tick();
        checks++;
        if (bpif.ovf_err !== 1'b0) begin
            errors++; $display("FAIL full_ovf_pulse got %b want 0", bpif.ovf_err);
        end
        checks++;
        if (bpif.wr_ready !== 1'b1 || bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL full_kill_empty got rdy=%b v=%b want 1 0", bpif.wr_ready, bpif.upd_valid);
        end
    endtask

    task automatic test_kill();
        act_q.delete(); exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            set_in(1, mk(10 + i), 0, 0, 0);
            tick();
        end
        set_in(0, '0, 1, 0, 0);
        tick();
        set_in(0, '0, 0, 1, 0);
        tick();
        set_in(0, '0, 0, 0, 1);
        tick();
        checks++;
        if (bpif.upd_valid !== 1'b0 || bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL kill_drain got v=%b rdy=%b want 0 1", bpif.upd_valid, bpif.wr_ready);
        end
        set_in(1, mk(20), 0, 0, 0);
        tick();
        set_in(0, '0, 1, 0, 0);
        tick();
        checks++;
        if (bpif.upd_valid !== 1'b1 || bpif.upd_pc !== mk(20).pc || bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL kill_rewrite got v=%b pc=%h want 1 %h", bpif.upd_valid, bpif.upd_pc, mk(20).pc);
        end
        set_in(0, '0, 0, 0, 1);
        tick();
        checks++;
        if (act_q.size() != 2 || exp_q.size() != 2) begin
            errors++; $display("FAIL kill_count got %0d want 2", act_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_q[i] !== exp_q[i] || act_q[i] !== mk(i == 0 ? 10 : 20)) begin
                    errors++; $display("FAIL kill_pkt%0d got %h want %h", i, act_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_commit_kill();
        act_q.delete(); exp_q.delete();
        set_in(1, mk(40), 0, 0, 0); tick();
        set_in(1, mk(41), 0, 0, 0); tick();
        set_in(1, mk(42), 1, 1, 0);
        tick();
        checks++;
        if (bpif.ovf_err !== 1'b0 || bpif.cm_err !== 1'b0) begin
            errors++; $display("FAIL ck_err got ovf=%b cm=%b want 0 0", bpif.ovf_err, bpif.cm_err);
        end
        checks++;
        if (bpif.upd_valid !== 1'b1 || bpif.upd_pc !== mk(40).pc || bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL ck_head got v=%b pc=%h want 1 %h", bpif.upd_valid, bpif.upd_pc, mk(40).pc);
        end
        set_in(0, '0, 0, 0, 1);
        tick();
        checks++;
        if (bpif.upd_valid !== 1'b0 || act_q.size() != 1 || exp_q.size() != 1 || act_q[0] !== mk(40)) begin
            errors++; $display("FAIL ck_drain got v=%b n=%0d want 0 1", bpif.upd_valid, act_q.size());
        end
    endtask

    task automatic test_empty_commit();
        act_q.delete(); exp_q.delete();
        set_in(0, '0, 1, 0, 0);
        tick();
        checks++;
        if (bpif.cm_err !== 1'b1 || m_cmerr !== 1'b1) begin
            errors++; $display("FAIL ec_cm_err got %b want 1", bpif.cm_err);
        end
        checks++;
        if (bpif.upd_valid !== 1'b0 || bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL ec_ptrs got v=%b rdy=%b want 0 1", bpif.upd_valid, bpif.wr_ready);
        end
        set_in(1, mk(50), 1, 0, 0);
        tick();
        checks++;
        if (bpif.cm_err !== 1'b1 || bpif.upd_valid !== 1'b0) begin
            errors++; $display("FAIL ec_wr_cm got cm=%b v=%b want 1 0", bpif.cm_err, bpif.upd_valid);
        end
        set_in(0, '0, 1, 0, 0);
        tick();
        checks++;
        if (bpif.cm_err !== 1'b0 || bpif.upd_valid !== 1'b1 || bpif.upd_pc !== mk(50).pc) begin
            errors++; $display("FAIL ec_late_cm got cm=%b v=%b pc=%h want 0 1 %h",
                               bpif.cm_err, bpif.upd_valid, bpif.upd_pc, mk(50).pc);
        end
        set_in(0, '0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(1, mk(60), 0, 0, 0); tick();
        set_in(1, mk(61), 1, 0, 0); tick();
        set_in(0, '0, 1, 0, 0); tick();
        set_in(0, '0, 0, 0, 0);
        checks++;
        if (bpif.upd_valid !== 1'b1) begin
            errors++; $display("FAIL rm_pre got v=%b want 1", bpif.upd_valid);
        end
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        checks++;
        if (bpif.upd_valid !== 1'b0 || bpif.wr_ready !== 1'b1) begin
            errors++; $display("FAIL rm_post got v=%b rdy=%b want 0 1", bpif.upd_valid, bpif.wr_ready);
        end
    endtask

    task automatic test_stream();
        int sent;
        bit wv;
        act_q.delete(); exp_q.delete();
        rst_l = 1'b0;
        set_in(0, '0, 0, 0, 0);
        tick();
        rst_l = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 80 && (sent < 10 || act_q.size() < 10); cyc++) begin
            wv = (sent < 10);
            set_in(wv, mk(100 + sent), (m_ent.size() - m_ncm) > 0, 0, cyc[0]);
            if (m_ncm != 0) begin
                checks++;
                if (bpif.upd_valid !== 1'b1 ||
                    {bpif.upd_pc, bpif.upd_misp, bpif.upd_ataken, bpif.upd_hist} !== m_ent[0]) begin
                    errors++; $display("FAIL stream_head cyc%0d got v=%b pc=%h want 1 %h",
                                       cyc, bpif.upd_valid, bpif.upd_pc, m_ent[0].pc);
                end
            end
            if (wv && m_ent.size() != DEPTH)
                sent++;
            tick();
        end
        checks++;
        if (act_q.size() != 10 || exp_q.size() != 10) begin
            errors++; $display("FAIL stream_count got %0d want 10", act_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (act_q[i] !== mk(100 + i) || act_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stream_pkt%0d got %h want %h", i, act_q[i], mk(100 + i));
                end
            end
        end
`ifdef EXU_BPQ_STATS_EN
        checks++;
        if (stat_upd_cnt !== 16'd10 || stat_misp_cnt !== 16'd5) begin
            errors++; $display("FAIL stream_stats got upd=%0d misp=%0d want 10 5", stat_upd_cnt, stat_misp_cnt);
        end
`endif
    endtask

    initial begin
        set_in(0, '0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_kill();
        test_commit_kill();
        test_empty_commit();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
